// File: rtl/cut_vector_sequencer.sv
// ---------------------------------------------------------------------------
// cut_vector_sequencer
//   Steps an ISCAS85 combinational circuit-under-test through a set of stored
//   input vectors. For each vector it fetches it from a synchronous vector RAM,
//   drives it onto the CUT, waits a programmable settle window, then captures
//   the CUT outputs. It can also compare the capture against a golden RAM and
//   count mismatches, which are aging-induced timing failures.
//
// Ports
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   start          begin a run (honoured only while idle)
//   abort          stop the run at once; overrides every other event
//   num_vec        vectors in the run, clamped to DEPTH, latched at start
//   settle_cycles  extra wait cycles before each capture, latched at start
//   cmp_en         compare captures against golden data, latched at start
//   mem_addr       read address shared by the vector and golden RAMs
//   vec_rdata      vector RAM read data (one cycle after mem_addr)
//   gold_rdata     golden RAM read data (one cycle after mem_addr)
//   cut_in         registered drive to the CUT inputs
//   cut_out        CUT outputs
//   cap_valid      one-cycle pulse qualifying cap_data / cap_idx
//   cap_data       captured CUT outputs
//   cap_idx        index of the captured vector
//   busy           high whenever the sequencer is not idle
//   done           one-cycle pulse at the end of a completed run
//   err_cnt        mismatch count of the current / last run
//   first_err_vld  at least one mismatch seen in this run
//   first_err_idx  index of the first mismatching vector
// ---------------------------------------------------------------------------
module cut_vector_sequencer #(
    parameter int IN_W     = 207,
    parameter int OUT_W    = 108,
    parameter int ADDR_W   = 3,
    parameter int DEPTH    = 7,
    parameter int SETTLE_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W:0]     num_vec,
    input  logic [SETTLE_W-1:0] settle_cycles,
    input  logic                cmp_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [IN_W-1:0]     vec_rdata,
    input  logic [OUT_W-1:0]    gold_rdata,
    output logic [IN_W-1:0]     cut_in,
    input  logic [OUT_W-1:0]    cut_out,
    output logic                cap_valid,
    output logic [OUT_W-1:0]    cap_data,
    output logic [ADDR_W-1:0]   cap_idx,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     err_cnt,
    output logic                first_err_vld,
    output logic [ADDR_W-1:0]   first_err_idx
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_LOAD    = 3'd2;
    localparam logic [2:0] ST_SETTLE  = 3'd3;
    localparam logic [2:0] ST_CAPTURE = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    // True when the captured word differs from the golden word in any bit.
    function automatic logic word_differs(input logic [OUT_W-1:0] a,
                                          input logic [OUT_W-1:0] b);
        return |(a ^ b);
    endfunction

    logic [2:0]          state_r;
    logic [2:0]          next_state_s;
    logic [ADDR_W:0]     n_r;
    logic [SETTLE_W-1:0] settle_r;
    logic [SETTLE_W-1:0] cnt_r;
    logic                cmp_en_r;
    logic [ADDR_W-1:0]   idx_r;
    logic [ADDR_W:0]     num_clamped_s;
    logic                last_s;
    logic                mismatch_s;

    // Clamp the requested vector count to the number of stored vectors.
    always_comb begin
        num_clamped_s = num_vec;
        if (num_vec > DEPTH_C) begin
            num_clamped_s = DEPTH_C;
        end else begin
            num_clamped_s = num_vec;
        end
    end

    // n_r is never 0 while a vector is in flight, so n_r-1 cannot wrap here.
    assign last_s     = ({1'b0, idx_r} == (n_r - 1'b1));
    assign mismatch_s = cmp_en_r & word_differs(cut_out, gold_rdata);

    // Next-state decode; abort overrides every transition.
    always_comb begin
        next_state_s = state_r;
        if (abort) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        next_state_s = (num_clamped_s == {(ADDR_W+1){1'b0}}) ? ST_DONE : ST_FETCH;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                ST_FETCH:  next_state_s = ST_LOAD;
                ST_LOAD:   next_state_s = ST_SETTLE;
                ST_SETTLE: begin
                    if (cnt_r == {SETTLE_W{1'b0}}) begin
                        next_state_s = ST_CAPTURE;
                    end else begin
                        next_state_s = ST_SETTLE;
                    end
                end
                ST_CAPTURE: next_state_s = last_s ? ST_DONE : ST_FETCH;
                ST_DONE:    next_state_s = ST_IDLE;
                default:    next_state_s = ST_IDLE;
            endcase
        end
    end

    // FSM state, datapath registers and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            n_r           <= '0;
            settle_r      <= '0;
            cnt_r         <= '0;
            cmp_en_r      <= 1'b0;
            idx_r         <= '0;
            mem_addr      <= '0;
            cut_in        <= '0;
            cap_valid     <= 1'b0;
            cap_data      <= '0;
            cap_idx       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_cnt       <= '0;
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
        end else begin
            state_r   <= next_state_s;
            busy      <= (next_state_s != ST_IDLE);
            cap_valid <= 1'b0;
            done      <= 1'b0;
            if (!abort) begin
                case (state_r)
                    ST_IDLE: begin
                        if (start) begin
                            n_r           <= num_clamped_s;
                            settle_r      <= settle_cycles;
                            cmp_en_r      <= cmp_en;
                            idx_r         <= '0;
                            // Address is presented on entry to FETCH so the
                            // synchronous RAM data is ready for LOAD.
                            mem_addr      <= '0;
                            err_cnt       <= '0;
                            first_err_vld <= 1'b0;
                            first_err_idx <= '0;
                        end
                    end
                    ST_LOAD: begin
                        cut_in <= vec_rdata;
                        cnt_r  <= settle_r;
                    end
                    ST_SETTLE: begin
                        if (cnt_r != {SETTLE_W{1'b0}}) begin
                            cnt_r <= cnt_r - 1'b1;
                        end
                    end
                    ST_CAPTURE: begin
                        cap_data  <= cut_out;
                        cap_idx   <= idx_r;
                        cap_valid <= 1'b1;
                        if (mismatch_s) begin
                            err_cnt <= err_cnt + 1'b1;
                            if (!first_err_vld) begin
                                first_err_vld <= 1'b1;
                                first_err_idx <= idx_r;
                            end
                        end
                        if (!last_s) begin
                            idx_r    <= idx_r + 1'b1;
                            mem_addr <= idx_r + 1'b1;
                        end
                    end
                    ST_DONE: done <= 1'b1;
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cut_vector_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cut_vector_sequencer
//   Bench for cut_vector_sequencer. Provides synchronous vector and golden
//   RAMs, a combinational CUT model, and a scoreboard of expected captures
//   (index, data, arrival cycle) filled when a run is launched and drained as
//   cap_valid pulses arrive.
// ---------------------------------------------------------------------------
module tb_cut_vector_sequencer;

    localparam int IN_W     = 207;
    localparam int OUT_W    = 108;
    localparam int ADDR_W   = 3;
    localparam int DEPTH    = 7;
    localparam int SETTLE_W = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic                abort;
    logic [ADDR_W:0]     num_vec;
    logic [SETTLE_W-1:0] settle_cycles;
    logic                cmp_en;
    logic [ADDR_W-1:0]   mem_addr;
    logic [IN_W-1:0]     vec_rdata;
    logic [OUT_W-1:0]    gold_rdata;
    logic [IN_W-1:0]     cut_in;
    logic [OUT_W-1:0]    cut_out;
    logic                cap_valid;
    logic [OUT_W-1:0]    cap_data;
    logic [ADDR_W-1:0]   cap_idx;
    logic                busy;
    logic                done;
    logic [ADDR_W:0]     err_cnt;
    logic                first_err_vld;
    logic [ADDR_W-1:0]   first_err_idx;

    logic [IN_W-1:0]  vec_mem  [8];
    logic [OUT_W-1:0] gold_mem [8];

    typedef struct {
        logic [ADDR_W-1:0] idx;
        logic [OUT_W-1:0]  data;
        int                t;
    } cap_exp_t;

    cap_exp_t sb_q[$];
    int exp_done_t;
    int caps;
    int dones;
    int checks   = 0;
    int failures = 0;

    cut_vector_sequencer #(
        .IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .SETTLE_W(SETTLE_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .num_vec(num_vec), .settle_cycles(settle_cycles), .cmp_en(cmp_en),
        .mem_addr(mem_addr), .vec_rdata(vec_rdata), .gold_rdata(gold_rdata),
        .cut_in(cut_in), .cut_out(cut_out),
        .cap_valid(cap_valid), .cap_data(cap_data), .cap_idx(cap_idx),
        .busy(busy), .done(done), .err_cnt(err_cnt),
        .first_err_vld(first_err_vld), .first_err_idx(first_err_idx)
    );

    // Free-running bench clock.
    always #5 clk = ~clk;

    // Synchronous vector and golden RAMs.
    always @(posedge clk) begin
        vec_rdata  <= vec_mem[mem_addr];
        gold_rdata <= gold_mem[mem_addr];
    end

    // Stand-in combinational CUT.
    function automatic logic [OUT_W-1:0] cut_model(input logic [IN_W-1:0] v);
        return v[OUT_W-1:0] ^ v[IN_W-1:IN_W-OUT_W] ^ {v[50:0], v[107:51]};
    endfunction

    assign cut_out = cut_model(cut_in);

    // Count one comparison and report it when it does not hold.
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Every output must be zero (reset state).
    task automatic check_zero(input string tag);
        chk({tag, "_mem_addr"}, 128'(mem_addr), 128'd0);
        chk({tag, "_cut_in"}, 128'(|cut_in), 128'd0);
        chk({tag, "_cap_valid"}, 128'(cap_valid), 128'd0);
        chk({tag, "_cap_data"}, 128'(cap_data), 128'd0);
        chk({tag, "_cap_idx"}, 128'(cap_idx), 128'd0);
        chk({tag, "_busy"}, 128'(busy), 128'd0);
        chk({tag, "_done"}, 128'(done), 128'd0);
        chk({tag, "_err_cnt"}, 128'(err_cnt), 128'd0);
        chk({tag, "_ferr_vld"}, 128'(first_err_vld), 128'd0);
        chk({tag, "_ferr_idx"}, 128'(first_err_idx), 128'd0);
    endtask

    // Fill the scoreboard for a run and present start to the DUT.
    task automatic launch(input int num, input int s, input bit cmp);
        int n;
        n = (num > DEPTH) ? DEPTH : num;
        sb_q.delete();
        for (int k = 0; k < n; k++) begin
            cap_exp_t e;
            e.idx  = ADDR_W'(k);
            e.data = cut_model(vec_mem[k]);
            e.t    = (k + 1) * (s + 4) + 1;
            sb_q.push_back(e);
        end
        exp_done_t = n * (s + 4) + 2;
        @(negedge clk);
        num_vec       = (ADDR_W + 1)'(num);
        settle_cycles = SETTLE_W'(s);
        cmp_en        = cmp;
        start         = 1'b1;
    endtask

    // Observe the run cycle by cycle (t = cycles since start was sampled).
    task automatic watch(input bit exp_done, input int abort_t, input int rst_t,
                         input int dup_start_t, input int limit);
        bit fin;
        cap_exp_t e;
        fin   = 1'b0;
        caps  = 0;
        dones = 0;
        for (int t = 1; t <= limit && !fin; t++) begin
            @(negedge clk);
            if (cap_valid) begin
                caps++;
                if (sb_q.size() == 0) begin
                    chk("cap_unexpected", 128'd1, 128'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("cap_idx", 128'(cap_idx), 128'(e.idx));
                    chk("cap_data", 128'(cap_data), 128'(e.data));
                    chk("cap_time", 128'(t), 128'(e.t));
                end
            end
            if (done) begin
                dones++;
                chk("done_time", 128'(t), 128'(exp_done_t));
                chk("sb_drained", 128'(sb_q.size()), 128'd0);
                chk("busy_after_done", 128'(busy), 128'd0);
                fin = 1'b1;
            end
            if (abort_t > 0 && t == abort_t + 1) begin
                chk("abort_busy", 128'(busy), 128'd0);
                chk("abort_cap_valid", 128'(cap_valid), 128'd0);
            end
            // Inputs changing after start must not affect the latched run.
            if (t == 1) begin
                num_vec       = 4'd1;
                settle_cycles = 8'd9;
                cmp_en        = ~cmp_en;
            end
            start = (t == dup_start_t) ? 1'b1 : 1'b0;
            abort = (t == abort_t) ? 1'b1 : 1'b0;
            if (t == rst_t) begin
                rst_n = 1'b0;
                #1;
                check_zero("rst_mid");
                fin = 1'b1;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        if (exp_done && dones == 0) begin
            chk("done_timeout", 128'd0, 128'd1);
        end
    endtask

    task automatic check_result(input string tag, input int e_cnt, input bit e_vld, input int e_idx);
        chk({tag, "_err_cnt"}, 128'(err_cnt), 128'(e_cnt));
        chk({tag, "_ferr_vld"}, 128'(first_err_vld), 128'(e_vld));
        if (e_vld) begin
            chk({tag, "_ferr_idx"}, 128'(first_err_idx), 128'(e_idx));
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        num_vec = '0; settle_cycles = '0; cmp_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            for (int b = 0; b < IN_W; b++) begin
                vec_mem[i][b] = 1'($urandom);
            end
            gold_mem[i] = cut_model(vec_mem[i]);
        end
        repeat (3) @(negedge clk);
        check_zero("rst_init");
        rst_n = 1'b1;

        // Full run, clean golden; a stray start mid-run must be ignored.
        launch(7, 0, 1'b1);
        watch(1'b1, 0, 0, 10, 40);
        check_result("clean", 0, 1'b0, 0);

        // Golden entry 3 corrupted.
        gold_mem[3][0] = ~gold_mem[3][0];
        launch(7, 0, 1'b1);
        watch(1'b1, 0, 0, 0, 40);
        check_result("gold3", 1, 1'b1, 3);

        // Same corruption with comparison disabled.
        launch(7, 0, 1'b0);
        watch(1'b1, 0, 0, 0, 40);
        check_result("nocmp", 0, 1'b0, 0);

        // Two corrupted entries, first one reported.
        gold_mem[5][7] = ~gold_mem[5][7];
        launch(6, 2, 1'b1);
        watch(1'b1, 0, 0, 0, 60);
        check_result("gold35", 2, 1'b1, 3);
        gold_mem[3] = cut_model(vec_mem[3]);
        gold_mem[5] = cut_model(vec_mem[5]);

        // Empty run clears the previous error count.
        launch(0, 0, 1'b1);
        watch(1'b1, 0, 0, 0, 10);
        chk("empty_caps", 128'(caps), 128'd0);
        check_result("empty", 0, 1'b0, 0);

        // Over-range count clamps to DEPTH with a longer settle window.
        launch(15, 5, 1'b1);
        watch(1'b1, 0, 0, 0, 80);
        chk("clamp_caps", 128'(caps), 128'd7);
        check_result("clamp", 0, 1'b0, 0);

        // Abort in SETTLE of vector 2 keeps the partial error state.
        gold_mem[1][2] = ~gold_mem[1][2];
        launch(7, 3, 1'b1);
        watch(1'b0, 18, 0, 0, 30);
        chk("abort_caps", 128'(caps), 128'd2);
        chk("abort_dones", 128'(dones), 128'd0);
        check_result("abort", 1, 1'b1, 1);
        gold_mem[1] = cut_model(vec_mem[1]);

        // Fresh start after abort runs from index 0.
        launch(3, 0, 1'b1);
        watch(1'b1, 0, 0, 0, 20);
        check_result("rerun", 0, 1'b0, 0);

        // start together with abort while idle: abort wins.
        @(negedge clk);
        num_vec = 4'd3; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", 128'(busy), 128'd0);

        // Reset in CAPTURE of vector 2.
        launch(7, 0, 1'b1);
        watch(1'b0, 0, 12, 0, 20);
        chk("rst_caps", 128'(caps), 128'd2);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequencer must be idle and fully usable after reset.
        launch(2, 1, 1'b1);
        watch(1'b1, 0, 0, 0, 20);
        check_result("post_rst", 0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
